// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised register file, DEPTH = 2**ADDR_W words of DATA_W bits,
// one write port and two independent registered read ports (A = R, B = S) with a
// one-cycle latency and a valid strobe each. A bulk-clear engine zeroes one word
// per cycle while busy is high; writes arriving then (or together with clr) are
// dropped and flagged on wr_err.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   we, W_adr, W       write enable / address / data
//   R_re, R_adr        port A read request / address -> R, R_vld
//   S_re, S_adr        port B read request / address -> S, S_vld
//   clr                bulk-clear request (pulse)
//   busy               clear sequence in progress
//   wr_err             one-cycle pulse when a write was dropped
//
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding, where a
// read of the address being written in the same cycle returns the new data.
// Default build is read-first (returns the pre-write contents).
module reg_file_2r1w #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] W_adr,
  input  logic [DATA_W-1:0] W,
  input  logic              R_re,
  input  logic [ADDR_W-1:0] R_adr,
  output logic [DATA_W-1:0] R,
  output logic              R_vld,
  input  logic              S_re,
  input  logic [ADDR_W-1:0] S_adr,
  output logic [DATA_W-1:0] S,
  output logic              S_vld,
  input  logic              clr,
  output logic              busy,
  output logic              wr_err
);

  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] r_q, s_q;
  logic              r_vld_q, s_vld_q, wr_err_q;

  logic              clearing;
  logic              wr_zero, wr_acc, wr_drop;
  logic              rd_a, rd_b;
  logic [DATA_W-1:0] r_d, s_d;

  assign clearing = (state_q == StClear);

  // Writes to the hardwired zero register vanish without an error pulse.
  assign wr_zero = (ZERO_REG != 0) && (W_adr == '0);
  // clr beats a coincident write.
  assign wr_acc  = we && !clearing && !clr && !wr_zero;
  assign wr_drop = we && !wr_zero && (clearing || clr);

  assign rd_a = R_re && !clearing;
  assign rd_b = S_re && !clearing;

  always_comb begin
    r_d = mem_q[R_adr];
    s_d = mem_q[S_adr];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc && (W_adr == R_adr)) r_d = W;
    if (wr_acc && (W_adr == S_adr)) s_d = W;
`endif
    if ((ZERO_REG != 0) && (R_adr == '0)) r_d = '0;
    if ((ZERO_REG != 0) && (S_adr == '0)) s_d = '0;
  end

  // Storage: the clear engine owns the array while busy, so it never races a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clearing) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= '0;
    end else if (wr_acc) begin
      mem_q[W_adr] <= W;
    end
  end

  // Clear sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr) state_q <= StClear;
          cnt_q <= '0;
        end
        StClear: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + (ADDR_W + 1)'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Read ports and error strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q      <= '0;
      s_q      <= '0;
      r_vld_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (rd_a) r_q <= r_d;
      if (rd_b) s_q <= s_d;
      r_vld_q  <= rd_a;
      s_vld_q  <= rd_b;
      wr_err_q <= wr_drop;
    end
  end

  assign R      = r_q;
  assign S      = s_q;
  assign R_vld  = r_vld_q;
  assign S_vld  = s_vld_q;
  assign busy   = clearing;
  assign wr_err = wr_err_q;

endmodule
